title_draw: RTL
===============

# title_draw

Pixel-stage consumer of the 16-row × 41-bit title bitmap ROM.
- Maps the VGA scan position (DrawX/DrawY) onto the scaled title box and drives the ROM row address.
- Selects the bitmap bit for the current pixel and registers a one-bit `is_title` for the color mapper.
- Owns the title animation: slide-in from the top at start, optional blink while shown, dismiss.

## Interface
Parameters:
- `X_POS`, 238: left edge of title box, pixels.
- `Y_START`, 0: box top at the start of the slide.
- `Y_FINAL`, 160: box top at rest.
- `SLIDE_STEP`, 8: pixels moved per frame during the slide.
- `SCALE_LOG2`, 2: each bitmap bit is 2^SCALE_LOG2 pixels square. Box is 164×64 at the default.
- `BLINK_FRAMES`, 30: frames per blink half-period.

Ports:
- `Clk`, in, 1: system clock. One clock domain; all state on its rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `frame_clk`, in, 1: VGA vertical sync level. The block detects its rising edge internally.
- `start`, in, 1: one-cycle pulse that begins the slide-in.
- `dismiss`, in, 1: one-cycle pulse that hides the title.
- `blink_en`, in, 1: enables blinking while shown.
- `DrawX`, in, 10: current pixel column.
- `DrawY`, in, 10: current pixel row.
- `rom_addr`, out, 4: bitmap row address. Combinational.
- `rom_data`, in, 41: bitmap row. Combinational return from the ROM; bit 40 is the leftmost column.
- `is_title`, out, 1: current pixel is lit title. Registered.
- `title_done`, out, 1: high while in SHOWN.
- `title_y`, out, 10: current box top.

## Operation
Frame edge:
- `frame_edge = frame_clk & ~frame_prev`.
- `frame_prev` resets to 1, so a high `frame_clk` at reset release produces no edge.

States:
- HIDDEN, SLIDE, SHOWN. Reset state is HIDDEN.
- HIDDEN: `start` sets `title_y` = Y_START, sets `visible` = 1, and goes to SLIDE.
- SLIDE: on `frame_edge`, if `title_y + SLIDE_STEP >= Y_FINAL`, set `title_y` = Y_FINAL, clear `blink_cnt`, and go to SHOWN. Otherwise `title_y += SLIDE_STEP`.
- SHOWN, `blink_en`=1: on `frame_edge`, `blink_cnt` counts 0..BLINK_FRAMES-1. At wrap it returns to 0 and toggles `visible`.
- SHOWN, `blink_en`=0: `visible` is forced to 1 and `blink_cnt` holds at 0.
- `start` in SLIDE or SHOWN restarts the slide from Y_START with `visible` = 1.
- `dismiss` in any state: go to HIDDEN and set `visible` = 0.

Priority in a single cycle: `Reset` > `dismiss` > `start` > `frame_edge`.

Pixel mapping (combinational, 11-bit unsigned arithmetic to avoid wrap):
- `in_x = DrawX >= X_POS && DrawX < X_POS + (41 << SCALE_LOG2)`.
- `in_y = DrawY >= title_y && DrawY < title_y + (16 << SCALE_LOG2)`.
- `col = (DrawX - X_POS) >> SCALE_LOG2`, range 0..40.
- `row = (DrawY - title_y) >> SCALE_LOG2`, range 0..15.
- `rom_addr = in_y ? row[3:0] : 0`.
- `is_title` next value = `(state != HIDDEN) && visible && in_x && in_y && rom_data[40 - col]`.
- When `in_x` is false, `col` is not used to index `rom_data`; that path yields 0.

## Timing
- Reset values: state HIDDEN, `title_y` = Y_START, `visible` = 0, `blink_cnt` = 0, `is_title` = 0, `title_done` = 0, `frame_prev` = 1.
- `rom_addr` tracks DrawY and `title_y` in the same cycle. `rom_data` is read in that same cycle.
- `is_title` latency is 1 Clk from DrawX/DrawY. The color mapper delays its coordinates to match.
- `title_y` and state update in the cycle after the qualifying `frame_edge` or pulse. Pixels use the new `title_y` from the next cycle on. A mid-frame update is allowed.
- `title_done` is registered with the state and rises one cycle after the final slide step.
- Slide at defaults: 20 frame edges from Y_START=0 to Y_FINAL=160.
- `Reset` mid-slide returns every register to its reset value on the next edge. `start` must be re-issued.

## Test plan
- Reset with `frame_clk`=1: `is_title`=0, `title_done`=0, `title_y`=0. No spurious frame edge after release.
- `start`, then 19 `frame_clk` edges: `title_y`=152, `title_done`=0. The 20th edge gives `title_y`=160 and `title_done`=1 one cycle later.
- In SHOWN, DrawY=168, DrawX=238: `rom_addr`=2. With `rom_data[40]`=1, `is_title`=1 on the next cycle.
- Same setup with DrawX=401 and `rom_data[0]`=1: `is_title`=1. DrawX=402: `is_title`=0. DrawY=224: `rom_addr`=0 and `is_title`=0.
- SHOWN with `blink_en`=1: after 30 frame edges `visible` toggles to 0 and a lit pixel reads 0. After 30 more it is lit again.
- `start` and `dismiss` in the same cycle: state goes to HIDDEN. `Reset` at `title_y`=80: HIDDEN with `title_y`=0 next cycle.

Source files
------------

// File: rtl/title_draw.sv
// title_draw: maps the VGA scan position onto the scaled title box, addresses
// the 16x41 title bitmap ROM and produces a registered per-pixel is_title flag.
// Also owns the title animation: slide-in from the top, optional blink, dismiss.
module title_draw #(
    parameter int X_POS        = 238,
    parameter int Y_START      = 0,
    parameter int Y_FINAL      = 160,
    parameter int SLIDE_STEP   = 8,
    parameter int SCALE_LOG2   = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        start,
    input  logic        dismiss,
    input  logic        blink_en,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [3:0]  rom_addr,
    input  logic [40:0] rom_data,
    output logic        is_title,
    output logic        title_done,
    output logic [9:0]  title_y
);

    localparam logic [1:0] HIDDEN = 2'd0;
    localparam logic [1:0] SLIDE  = 2'd1;
    localparam logic [1:0] SHOWN  = 2'd2;

    localparam int CNT_W = $clog2(BLINK_FRAMES + 1);

    // Box geometry in 11 bits so X_POS + width never wraps.
    localparam logic [10:0] X_LO  = 11'(X_POS);
    localparam logic [10:0] BOX_W = 11'(41 << SCALE_LOG2);
    localparam logic [10:0] BOX_H = 11'(16 << SCALE_LOG2);
    localparam logic [10:0] STEP  = 11'(SLIDE_STEP);
    localparam logic [10:0] Y_FIN = 11'(Y_FINAL);

    logic [1:0]       state;
    logic             visible;
    logic [CNT_W-1:0] blink_cnt;
    logic             frame_prev;
    logic             frame_edge;

    logic [10:0] x_w, y_w, ty_w;
    logic [10:0] col_full, row_full;
    logic [5:0]  col;
    logic [5:0]  bit_idx;
    logic        in_x, in_y;
    logic        pix_bit;

    assign frame_edge = frame_clk & ~frame_prev;

    // Pixel-to-bitmap mapping; rom_data returns in the same cycle as rom_addr.
    always_comb begin
        x_w      = {1'b0, DrawX};
        y_w      = {1'b0, DrawY};
        ty_w     = {1'b0, title_y};
        in_x     = (x_w >= X_LO) && (x_w < X_LO + BOX_W);
        in_y     = (y_w >= ty_w) && (y_w < ty_w + BOX_H);
        col_full = (x_w - X_LO) >> SCALE_LOG2;
        row_full = (y_w - ty_w) >> SCALE_LOG2;
        col      = col_full[5:0];
        bit_idx  = 6'd40 - col;
        rom_addr = in_y ? row_full[3:0] : 4'd0;
        // Outside the box col is meaningless, so never use it as an index there.
        pix_bit  = 1'b0;
        if (in_x && (col <= 6'd40))
            pix_bit = rom_data[bit_idx];
    end

    // Animation FSM, frame-edge detector and the registered pixel output.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= HIDDEN;
            title_y    <= 10'(Y_START);
            visible    <= 1'b0;
            blink_cnt  <= '0;
            is_title   <= 1'b0;
            title_done <= 1'b0;
            frame_prev <= 1'b1;
        end else begin
            frame_prev <= frame_clk;
            is_title   <= (state != HIDDEN) && visible && in_x && in_y && pix_bit;
            if (dismiss) begin
                state      <= HIDDEN;
                visible    <= 1'b0;
                title_done <= 1'b0;
            end else if (start) begin
                state      <= SLIDE;
                title_y    <= 10'(Y_START);
                visible    <= 1'b1;
                title_done <= 1'b0;
            end else begin
                case (state)
                    SLIDE: begin
                        if (frame_edge) begin
                            if (ty_w + STEP >= Y_FIN) begin
                                title_y    <= 10'(Y_FINAL);
                                blink_cnt  <= '0;
                                state      <= SHOWN;
                                title_done <= 1'b1;
                            end else begin
                                title_y <= title_y + 10'(SLIDE_STEP);
                            end
                        end
                    end
                    SHOWN: begin
                        if (!blink_en) begin
                            visible   <= 1'b1;
                            blink_cnt <= '0;
                        end else if (frame_edge) begin
                            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                                blink_cnt <= '0;
                                visible   <= ~visible;
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
